// File: rtl/sisc_pkg.sv
// Shared definitions for the small SISC core: opcode and funct encodings,
// FSM state encoding, status bit positions and instruction field positions.
// Optional feature macro: SISC_SHIFT_EN (enables the SHL/SHR functs).
package sisc_pkg;

    typedef enum logic [3:0] {
        OP_NOP    = 4'h0,
        OP_ALU_RR = 4'h1,
        OP_ALU_RI = 4'h2,
        OP_HALT   = 4'hF
    } opcode_e;

    typedef enum logic [3:0] {
        FN_ADD = 4'h0,
        FN_SUB = 4'h1,
        FN_AND = 4'h2,
        FN_OR  = 4'h3,
        FN_XOR = 4'h4,
        FN_NOT = 4'h5,
        FN_SHL = 4'h6,
        FN_SHR = 4'h7
    } funct_e;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_WRITEBACK = 3'd3,
        ST_HALTED    = 3'd4
    } state_e;

    // Bit positions inside the 4-bit status word {C,N,V,Z}
    localparam int STAT_C = 3;
    localparam int STAT_N = 2;
    localparam int STAT_V = 1;
    localparam int STAT_Z = 0;

    // Instruction field positions
    localparam int OPC_HI = 31;
    localparam int OPC_LO = 28;
    localparam int FN_HI  = 27;
    localparam int FN_LO  = 24;
    localparam int RD_HI  = 23;
    localparam int RD_LO  = 20;
    localparam int RS_HI  = 19;
    localparam int RS_LO  = 16;
    localparam int RT_HI  = 15;
    localparam int RT_LO  = 12;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;

    // True when a 4-bit register specifier names a register that does not exist
    function automatic logic regOutOfRange(input logic [3:0] r, input int n);
        return int'({28'd0, r}) >= n;
    endfunction

endpackage

// File: rtl/sisc_rf.sv
// Register file for the SISC core: NREGS registers of DW bits, two
// combinational read ports and one synchronous write port. R0 always reads
// zero and ignores writes; out-of-range addresses read zero and are not written.
module sisc_rf #(
    parameter int DW    = 32,
    parameter int NREGS = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    i_raddrA,
    output logic [DW-1:0] o_rdataA,
    input  logic [3:0]    i_raddrB,
    output logic [DW-1:0] o_rdataB,
    input  logic          i_we,
    input  logic [3:0]    i_waddr,
    input  logic [DW-1:0] i_wdata
);

    localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

    logic [DW-1:0] r_regs [NREGS];
    logic          w_wrOk;
    logic          w_rdOkA;
    logic          w_rdOkB;

    assign w_wrOk  = i_we && (i_waddr != 4'd0) && (int'({28'd0, i_waddr}) < NREGS);
    assign w_rdOkA = (i_raddrA != 4'd0) && (int'({28'd0, i_raddrA}) < NREGS);
    assign w_rdOkB = (i_raddrB != 4'd0) && (int'({28'd0, i_raddrB}) < NREGS);

    assign o_rdataA = w_rdOkA ? r_regs[i_raddrA[AW-1:0]] : '0;
    assign o_rdataB = w_rdOkB ? r_regs[i_raddrB[AW-1:0]] : '0;

    // Register storage: cleared by reset, written only for valid non-zero targets
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wrOk) begin
            r_regs[i_waddr[AW-1:0]] <= i_wdata;
        end
    end

endmodule

// File: rtl/sisc_core_p.sv
// SISC core: non-pipelined FETCH/DECODE/EXECUTE/WRITEBACK machine with a
// small ALU, status flags and a HALT state. One instruction per 4 cycles.
// Optional feature macro: SISC_SHIFT_EN (SHL/SHR; otherwise funct 6/7 illegal).
module sisc_core_p #(
    parameter int DW    = 32,
    parameter int NREGS = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   instr,
    input  logic          instr_valid,
    output logic          instr_ready,
    output logic [3:0]    stat,
    output logic          wb_valid,
    output logic [3:0]    wb_addr,
    output logic [DW-1:0] wb_data,
    output logic          illegal,
    output logic          halted
);

    import sisc_pkg::*;

`ifdef SISC_SHIFT_EN
    localparam int     SHW     = $clog2(DW);
    localparam funct_e FN_LAST = FN_SHR;
`else
    localparam funct_e FN_LAST = FN_NOT;
`endif

    state_e        r_state;
    logic [31:0]   r_instr;
    logic [DW-1:0] r_a;
    logic [DW-1:0] r_b;
    logic [DW-1:0] r_result;
    logic [3:0]    r_stat;
    logic          r_wbValid;
    logic          r_illegal;

    logic [3:0]    w_op;
    logic [3:0]    w_fn;
    logic [3:0]    w_rd;
    logic [3:0]    w_rs;
    logic [3:0]    w_rt;
    logic [63:0]   w_immFull;
    logic [DW-1:0] w_imm;
    logic [DW-1:0] w_rdA;
    logic [DW-1:0] w_rdB;
    logic          w_isAlu;
    logic          w_fnBad;
    logic          w_bad;
    logic [DW:0]   w_sum;
    logic [DW-1:0] w_result;
    logic          w_carry;
    logic          w_ovf;
    logic [3:0]    w_newStat;

    assign w_op      = r_instr[OPC_HI:OPC_LO];
    assign w_fn      = r_instr[FN_HI:FN_LO];
    assign w_rd      = r_instr[RD_HI:RD_LO];
    assign w_rs      = r_instr[RS_HI:RS_LO];
    assign w_rt      = r_instr[RT_HI:RT_LO];
    assign w_immFull = {{48{r_instr[IMM_HI]}}, r_instr[IMM_HI:IMM_LO]};
    assign w_imm     = w_immFull[DW-1:0];
    assign w_isAlu   = (w_op == OP_ALU_RR) || (w_op == OP_ALU_RI);
    assign w_fnBad   = (w_fn > FN_LAST);

    sisc_rf #(
        .DW    (DW),
        .NREGS (NREGS)
    ) u_rf (
        .clk      (clk),
        .rst      (rst),
        .i_raddrA (w_rs),
        .o_rdataA (w_rdA),
        .i_raddrB (w_rt),
        .o_rdataB (w_rdB),
        .i_we     (r_wbValid),
        .i_waddr  (w_rd),
        .i_wdata  (r_result)
    );

    // Legality check; rt is only a register specifier for reg-reg ALU ops
    always_comb begin
        w_bad = 1'b0;
        case (w_op)
            OP_NOP, OP_HALT: w_bad = 1'b0;
            OP_ALU_RR: w_bad = w_fnBad || regOutOfRange(w_rd, NREGS) ||
                               regOutOfRange(w_rs, NREGS) || regOutOfRange(w_rt, NREGS);
            OP_ALU_RI: w_bad = w_fnBad || regOutOfRange(w_rd, NREGS) ||
                               regOutOfRange(w_rs, NREGS);
            default:   w_bad = 1'b1;
        endcase
    end

    // ALU: result plus carry/overflow, subtraction done as a + ~b + 1
    always_comb begin
        w_sum    = '0;
        w_result = '0;
        w_carry  = 1'b0;
        w_ovf    = 1'b0;
        case (w_fn)
            FN_ADD: begin
                w_sum    = {1'b0, r_a} + {1'b0, r_b};
                w_result = w_sum[DW-1:0];
                w_carry  = w_sum[DW];
                w_ovf    = (r_a[DW-1] == r_b[DW-1]) && (w_result[DW-1] != r_a[DW-1]);
            end
            FN_SUB: begin
                w_sum    = {1'b0, r_a} + {1'b0, ~r_b} + {{DW{1'b0}}, 1'b1};
                w_result = w_sum[DW-1:0];
                w_carry  = w_sum[DW];
                w_ovf    = (r_a[DW-1] != r_b[DW-1]) && (w_result[DW-1] != r_a[DW-1]);
            end
            FN_AND: w_result = r_a & r_b;
            FN_OR:  w_result = r_a | r_b;
            FN_XOR: w_result = r_a ^ r_b;
            FN_NOT: w_result = ~r_a;
`ifdef SISC_SHIFT_EN
            FN_SHL: w_result = r_a << r_b[SHW-1:0];
            FN_SHR: w_result = r_a >> r_b[SHW-1:0];
`endif
            default: w_result = '0;
        endcase
    end

    // Status word assembled from the ALU outputs
    always_comb begin
        w_newStat         = '0;
        w_newStat[STAT_C] = w_carry;
        w_newStat[STAT_N] = w_result[DW-1];
        w_newStat[STAT_V] = w_ovf;
        w_newStat[STAT_Z] = (w_result == '0);
    end

    // Sequencer: one state per cycle; wb_valid/illegal pulse during WRITEBACK
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_FETCH;
            r_instr   <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_result  <= '0;
            r_stat    <= '0;
            r_wbValid <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_wbValid <= 1'b0;
            r_illegal <= 1'b0;
            case (r_state)
                ST_FETCH: begin
                    if (instr_valid) begin
                        r_instr <= instr;
                        r_state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    r_a     <= w_rdA;
                    r_b     <= (w_op == OP_ALU_RR) ? w_rdB : w_imm;
                    r_state <= ST_EXECUTE;
                end
                ST_EXECUTE: begin
                    if (w_bad) begin
                        r_illegal <= 1'b1;
                    end else if (w_isAlu) begin
                        r_result  <= w_result;
                        r_stat    <= w_newStat;
                        r_wbValid <= 1'b1;
                    end
                    r_state <= ST_WRITEBACK;
                end
                ST_WRITEBACK: r_state <= (w_op == OP_HALT) ? ST_HALTED : ST_FETCH;
                ST_HALTED:    r_state <= ST_HALTED;
                default:      r_state <= ST_FETCH;
            endcase
        end
    end

    assign instr_ready = (r_state == ST_FETCH);
    assign halted      = (r_state == ST_HALTED);
    assign stat        = r_stat;
    assign wb_valid    = r_wbValid;
    assign wb_addr     = w_rd;
    assign wb_data     = r_result;
    assign illegal     = r_illegal;

endmodule

// File: tb/tb_sisc_core_p.sv
// Self-checking bench for sisc_core_p (DW=32, NREGS=8) using a reference
// model and a scoreboard queue of expected writeback/illegal outcomes.
// Honours SISC_SHIFT_EN for the expected shift behaviour.
module tb_sisc_core_p;

`ifdef SISC_SHIFT_EN
    localparam bit SHIFT_EN = 1'b1;
`else
    localparam bit SHIFT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] instr = '0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [3:0]  stat;
    logic        wb_valid;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    logic        illegal;
    logic        halted;

    sisc_core_p #(.DW(32), .NREGS(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .stat        (stat),
        .wb_valid    (wb_valid),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .illegal     (illegal),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [3:0]  stat;
    } expEntry_t;

    expEntry_t   sbQueue[$];
    logic [31:0] mReg [8];
    logic [3:0]  mStat;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] lastWbData;
    logic [3:0]  lastWbAddr;
    logic [3:0]  lastStat;
    logic        lastWbValid;
    logic        lastIllegal;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic resetModel();
        for (int i = 0; i < 8; i++) mReg[i] = '0;
        mStat = '0;
    endtask

    // Reference behaviour of one instruction; updates the model state
    function automatic expEntry_t refModel(input logic [31:0] ins);
        expEntry_t   e;
        logic [3:0]  op, fn, rd, rs, rt;
        logic [31:0] a, b, res;
        logic [32:0] full;
        logic        c, v, bad;
        op = ins[31:28]; fn = ins[27:24]; rd = ins[23:20]; rs = ins[19:16]; rt = ins[15:12];
        e.kind = 0; e.addr = rd; e.data = '0;
        a = (rs < 4'd8) ? mReg[rs[2:0]] : 32'd0;
        if (op == 4'h1) b = (rt < 4'd8) ? mReg[rt[2:0]] : 32'd0;
        else            b = {{16{ins[15]}}, ins[15:0]};
        res = '0; c = 1'b0; v = 1'b0; full = '0;
        if (op == 4'h1 || op == 4'h2) begin
            bad = (rd >= 4'd8) || (rs >= 4'd8) || (op == 4'h1 && rt >= 4'd8) ||
                  (fn > 4'd7) || (!SHIFT_EN && fn >= 4'd6);
            case (fn)
                4'd0: begin full = {1'b0, a} + {1'b0, b}; res = full[31:0]; c = full[32];
                            v = (a[31] == b[31]) && (res[31] != a[31]); end
                4'd1: begin full = 33'(a) - 33'(b); res = full[31:0]; c = (a >= b);
                            v = (a[31] != b[31]) && (res[31] != a[31]); end
                4'd2: res = a & b;
                4'd3: res = a | b;
                4'd4: res = a ^ b;
                4'd5: res = ~a;
                4'd6: res = a << b[4:0];
                4'd7: res = a >> b[4:0];
                default: res = '0;
            endcase
            if (bad) e.kind = 2;
            else begin
                e.kind = 1;
                e.data = res;
                mStat  = {c, res[31], v, (res == 32'd0)};
                if (rd != 4'd0) mReg[rd[2:0]] = res;
            end
        end else if (op != 4'h0 && op != 4'hF) begin
            e.kind = 2;
        end
        e.stat = mStat;
        return e;
    endfunction

    // Issue one instruction, then compare the WRITEBACK cycle against the scoreboard
    task automatic applyStimulus(input logic [31:0] ins);
        expEntry_t e;
        logic      accepted;
        int        waited;
        sbQueue.push_back(refModel(ins));
        @(negedge clk);
        instr = ins;
        instr_valid = 1'b1;
        accepted = 1'b0;
        waited = 0;
        while (!accepted && waited < 12) begin
            if (instr_ready) accepted = 1'b1;
            else begin
                @(negedge clk);
                waited++;
            end
        end
        checkOutput("accept", accepted, 1);
        e = sbQueue.pop_front();
        if (!accepted) begin
            instr_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 instr = ~ins;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        lastWbValid = wb_valid; lastIllegal = illegal;
        lastWbData  = wb_data;  lastWbAddr  = wb_addr; lastStat = stat;
        checkOutput("wbValid", wb_valid, (e.kind == 1));
        checkOutput("illegal", illegal, (e.kind == 2));
        if (e.kind == 1) begin
            checkOutput("wbAddr", wb_addr, e.addr);
            checkOutput("wbData", wb_data, e.data);
        end
        checkOutput("stat", stat, e.stat);
        @(negedge clk);
        checkOutput("pulseEnd", wb_valid | illegal, 0);
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int readyCount;
        int waited;
        int haltBad;
        int readyBad;

        // Reset state
        resetModel();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rstReady", instr_ready, 1);
        checkOutput("rstStat", stat, 0);
        checkOutput("rstWbValid", wb_valid, 0);
        checkOutput("rstIllegal", illegal, 0);
        checkOutput("rstHalted", halted, 0);

        // Basic add-immediate and register add
        applyStimulus(32'h2010_0005);
        checkOutput("addiAddr", lastWbAddr, 1);
        checkOutput("addiData", lastWbData, 5);
        applyStimulus(32'h1021_1000);
        checkOutput("addData", lastWbData, 10);
        checkOutput("addStat", lastStat, 4'b0000);

        // Subtract to zero: Z and C set
        applyStimulus(32'h1131_1000);
        checkOutput("subData", lastWbData, 0);
        checkOutput("subStat", lastStat, 4'b1001);

        // Build 0x7FFFFFFF in R4, then overflow it with ADDI 1
        applyStimulus(32'h2040_0001);
        for (int i = 0; i < 31; i++) applyStimulus(32'h1044_4000);
        applyStimulus(32'h1544_0000);
        checkOutput("notData", lastWbData, 32'h7FFF_FFFF);
        applyStimulus(32'h2044_0001);
        checkOutput("ovfData", lastWbData, 32'h8000_0000);
        checkOutput("ovfStat", lastStat, 4'b0110);

        // Illegal encodings: rd out of range, bad opcode, bad funct; then NOP
        applyStimulus(32'h1091_1000);
        checkOutput("r9Illegal", lastIllegal, 1);
        checkOutput("r9NoWb", lastWbValid, 0);
        checkOutput("r9Stat", lastStat, 4'b0110);
        applyStimulus(32'h7000_0000);
        checkOutput("op7Illegal", lastIllegal, 1);
        applyStimulus(32'h1821_1000);
        applyStimulus(32'h0000_0000);
        applyStimulus(32'h2050_0003);
        checkOutput("stableData", lastWbData, 3);

        // Throughput with instr_valid held high (NOP stream)
        @(negedge clk);
        instr = 32'h0000_0000;
        instr_valid = 1'b1;
        waited = 0;
        while (!instr_ready && waited < 12) begin
            @(negedge clk);
            waited++;
        end
        readyCount = 0;
        for (int i = 0; i < 16; i++) begin
            if (instr_ready) readyCount++;
            @(negedge clk);
        end
        instr_valid = 1'b0;
        checkOutput("throughput", readyCount, 4);

        // Shift left, or illegal when the shifter is not built
        applyStimulus(32'h2010_0001);
        applyStimulus(32'h2020_0004);
        applyStimulus(32'h1651_2000);
        if (SHIFT_EN) checkOutput("shlData", lastWbData, 16);
        else          checkOutput("shlIllegal", lastIllegal, 1);

        // Reset during EXECUTE of ADDI R1,R0,7 aborts it
        @(negedge clk);
        instr = 32'h2010_0007;
        instr_valid = 1'b1;
        waited = 0;
        while (!instr_ready && waited < 12) begin
            @(negedge clk);
            waited++;
        end
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        resetModel();
        #2;
        checkOutput("abortWb", wb_valid, 0);
        checkOutput("abortIllegal", illegal, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("abortReady", instr_ready, 1);
        applyStimulus(32'h1061_0000);
        checkOutput("abortR1", lastWbData, 0);

        // HALT: stays halted with instr_ready low while instructions are offered
        applyStimulus(32'hF000_0000);
        instr = 32'h2010_0005;
        instr_valid = 1'b1;
        haltBad = 0;
        readyBad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (halted !== 1'b1) haltBad++;
            if (instr_ready !== 1'b0) readyBad++;
            if (wb_valid !== 1'b0) haltBad++;
        end
        instr_valid = 1'b0;
        checkOutput("haltedHigh", haltBad, 0);
        checkOutput("haltedNoReady", readyBad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sisc_core_p.md
SISC_CORE_P -- requirements
Module: sisc_core_p

Interface
REQ-001 SHALL provide parameter DW, default 32, datapath and register width (legal 8..64).
REQ-002 SHALL provide parameter NREGS, default 16, number of architectural registers (legal 2..16).
REQ-003 SHALL provide port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL provide port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL provide port instr  input  32  instruction word.
REQ-006 SHALL provide port instr_valid  input  1  instr holds a valid instruction.
REQ-007 SHALL provide port instr_ready  output  1  core accepts instr this cycle.
REQ-008 SHALL provide port stat  output  4  status {C,N,V,Z}.
REQ-009 SHALL provide port wb_valid  output  1  one-cycle pulse marking a register write.
REQ-010 SHALL provide port wb_addr  output  4  destination register of the write.
REQ-011 SHALL provide port wb_data  output  DW  value written.
REQ-012 SHALL provide port illegal  output  1  one-cycle pulse for a rejected instruction.
REQ-013 SHALL provide port halted  output  1  core stopped by HALT.

Function
REQ-014 Instruction fields SHALL be: opcode [31:28], funct [27:24], rd [23:20], rs [19:16], rt [15:12], imm [15:0] sign-extended to DW.
REQ-015 Opcodes SHALL be: 0 NOP, 1 ALU reg-reg (b = R[rt]), 2 ALU reg-imm (b = sext(imm)), F HALT; all others illegal.
REQ-016 Funct SHALL be: 0 ADD, 1 SUB (a+~b+1), 2 AND, 3 OR, 4 XOR, 5 NOT a, 6 SHL, 7 SHR logical; shift amount = b[log2(DW)-1:0]; 8..F illegal.
REQ-017 FSM states SHALL be FETCH, DECODE, EXECUTE, WRITEBACK, HALTED; instr_ready = 1 only in FETCH.
REQ-018 Transfer SHALL occur when instr_valid and instr_ready are both high at a rising edge; instr is captured and the FSM moves FETCH->DECODE; otherwise it stays in FETCH.
REQ-019 DECODE->EXECUTE->WRITEBACK->FETCH SHALL take one cycle each; an instruction accepted at edge N produces wb_valid during the cycle after edge N+2; maximum throughput is one instruction per 4 cycles.
REQ-020 instr SHALL be ignored outside FETCH; it need not remain stable after acceptance.
REQ-021 R0 SHALL read as zero; writes to R0 SHALL assert wb_valid but leave R0 unchanged.
REQ-022 rs, rt or rd >= NREGS, an illegal opcode or an illegal funct SHALL pulse illegal in WRITEBACK, with no register write and stat unchanged.
REQ-023 Legal ALU ops SHALL update stat in EXECUTE: Z = result==0, N = result[DW-1], C = carry out of ADD/SUB (0 for logic/shift ops), V = signed overflow of ADD/SUB (0 otherwise).
REQ-024 NOP SHALL pass through all states with no write, no illegal pulse and stat unchanged.
REQ-025 HALT SHALL move WRITEBACK->HALTED; halted = 1 and instr_ready = 0 until reset.
REQ-026 The register file SHALL read in DECODE and write in WRITEBACK; no read-after-write hazard exists because instructions do not overlap.

Reset
REQ-027 rst SHALL immediately force state FETCH, all registers 0, stat 0, and wb_valid, illegal and halted to 0; instr_ready SHALL be 1 after release.
REQ-028 rst asserted mid-instruction SHALL abort that instruction with no write and no pulse.

Configuration
REQ-029 With macro SISC_SHIFT_EN defined, funct 6/7 SHALL execute as SHL/SHR; undefined, funct 6/7 SHALL be illegal and no shifter SHALL be synthesised.

Structure
REQ-030 Package sisc_pkg SHALL hold the opcode and funct enums, the FSM state enum, the stat bit indices and the instruction field positions.
REQ-031 The register file SHALL be sub-module sisc_rf (parameters DW and NREGS; two read ports, one write port); the ALU and FSM stay in sisc_core_p.

Verification
REQ-032 A bench SHALL check: reset, ADDI R1,R0,5 -> wb_addr=1, wb_data=5 exactly 3 cycles after acceptance; then ADD R2,R1,R1 -> wb_data=10, stat=0000.
REQ-033 A bench SHALL check: R1=5, SUB R3,R1,R1 -> wb_data=0, Z=1, C=1; R4=0x7FFFFFFF, ADDI R4,R4,1 -> 0x80000000, V=1, N=1 (DW=32).
REQ-034 A bench SHALL check: NREGS=8, ADD R9,R1,R1 -> illegal pulse, no wb_valid, stat unchanged; opcode 7 -> illegal.
REQ-035 A bench SHALL check: instr_valid held high continuously -> instr_ready high exactly 1 cycle in 4; changing instr during DECODE has no effect.
REQ-036 A bench SHALL check: HALT -> halted=1, instr_ready=0 indefinitely; rst in EXECUTE of ADDI R1,R0,7 -> R1 stays 0 and instr_ready=1 after release.
REQ-037 A bench SHALL check: SHL R5,R1,R2 with R1=1, R2=4 -> 16 with SISC_SHIFT_EN defined, illegal pulse without it.
